// File: rtl/axis_ascon_bist.sv
// Built-in self-test traffic generator and tag checker for an Ascon AEAD encrypt/decrypt loopback.
// Optional macro ASCON_BIST_THROTTLE_EN adds a pseudo-random valid/ready throttle.
module axis_ascon_bist #(
  parameter int unsigned NUM_MSGS     = 16,
  parameter int unsigned LEN_W        = 3,
  parameter logic [63:0] SEED         = 64'h0123456789ABCDEF,
  parameter bit          KEEP_SUPPORT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [31:0]  tags_ok,
  output logic [31:0]  tag_errors,
  output logic         m_cmd_tvalid,
  input  logic         m_cmd_tready,
  output logic [511:0] m_cmd_tdata,
  output logic         m_ad_tvalid,
  input  logic         m_ad_tready,
  output logic         m_ad_tlast,
  output logic [127:0] m_ad_tdata,
  output logic [15:0]  m_ad_tkeep,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic [127:0] m_tdata,
  output logic [15:0]  m_tkeep,
  input  logic         s_tag_tvalid,
  output logic         s_tag_tready,
  input  logic [127:0] s_tag_tdata
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_STREAM, S_WAIT, S_FIN} state_t;

  localparam logic [63:0] AD_SEED = SEED ^ {8{8'hA5}};
  localparam logic [63:0] D_SEED  = SEED ^ {8{8'h5A}};
  localparam logic [63:0] T_SEED  = SEED ^ {8{8'h3C}};

  function automatic logic [63:0] xs_next(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic logic [63:0] rotl29(input logic [63:0] x);
    return {x[34:0], x[63:35]};
  endfunction

  // Smearing the highest set bit downward yields the contiguous keep mask.
  function automatic logic [15:0] last_keep(input logic [15:0] v);
    logic [15:0] k;
    k = v;
    k = k | (k >> 1);
    k = k | (k >> 2);
    k = k | (k >> 4);
    k = k | (k >> 8);
    if (k == 16'h0000) k = 16'h0001;
    if (!KEEP_SUPPORT) k = 16'hFFFF;
    return k;
  endfunction

  state_t             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               cmd_vld_q, cmd_vld_d, ad_vld_q, ad_vld_d, d_vld_q, d_vld_d;
  logic               ad_done_q, ad_done_d, d_done_q, d_done_d;
  logic [LEN_W-1:0]   ad_cnt_q, ad_cnt_d, d_cnt_q, d_cnt_d;
  logic [LEN_W-1:0]   ad_last_q, ad_last_d, d_last_q, d_last_d;
  logic [31:0]        msg_cnt_q, msg_cnt_d, tags_ok_q, tags_ok_d, tag_err_q, tag_err_d;
  logic [63:0]        cmd_x_q, cmd_x_d, ad_x_q, ad_x_d, d_x_q, d_x_d;
  logic               g_cmd, g_ad, g_d, tag_rdy;
  logic               cmd_hs, ad_hs, d_hs, tag_hs, ad_is_last, d_is_last;
  logic [511:0]       cmd_data;

`ifdef ASCON_BIST_THROTTLE_EN
  logic [63:0] thr_x_q, thr_x_d;
  assign g_cmd   = thr_x_q[0];
  assign g_ad    = thr_x_q[1];
  assign g_d     = thr_x_q[2];
  assign tag_rdy = busy_q & thr_x_q[3];
`else
  assign g_cmd   = 1'b1;
  assign g_ad    = 1'b1;
  assign g_d     = 1'b1;
  assign tag_rdy = busy_q;
`endif

  assign cmd_hs     = cmd_vld_q & m_cmd_tready;
  assign ad_hs      = ad_vld_q & m_ad_tready;
  assign d_hs       = d_vld_q & m_tready;
  assign tag_hs     = s_tag_tvalid & tag_rdy;
  assign ad_is_last = (ad_cnt_q == ad_last_q);
  assign d_is_last  = (d_cnt_q == d_last_q);

  always_comb begin
    cmd_data = '0;
    for (int i = 0; i < 4; i++) cmd_data[128*i +: 128] = {cmd_x_q ^ 64'(i), rotl29(cmd_x_q)};
    cmd_data[256] = 1'b1;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign tags_ok      = tags_ok_q;
  assign tag_errors   = tag_err_q;
  assign m_cmd_tvalid = cmd_vld_q;
  assign m_cmd_tdata  = cmd_data;
  assign m_ad_tvalid  = ad_vld_q;
  assign m_ad_tlast   = ad_is_last;
  assign m_ad_tdata   = {ad_x_q, rotl29(ad_x_q)};
  assign m_ad_tkeep   = ad_is_last ? last_keep(ad_x_q[15:0]) : 16'hFFFF;
  assign m_tvalid     = d_vld_q;
  assign m_tlast      = d_is_last;
  assign m_tdata      = {d_x_q, rotl29(d_x_q)};
  assign m_tkeep      = d_is_last ? last_keep(d_x_q[15:0]) : 16'hFFFF;
  assign s_tag_tready = tag_rdy;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    cmd_vld_d = cmd_vld_q;
    ad_vld_d  = ad_vld_q;
    d_vld_d   = d_vld_q;
    ad_done_d = ad_done_q;
    d_done_d  = d_done_q;
    ad_cnt_d  = ad_cnt_q;
    d_cnt_d   = d_cnt_q;
    ad_last_d = ad_last_q;
    d_last_d  = d_last_q;
    msg_cnt_d = msg_cnt_q;
    tags_ok_d = tags_ok_q;
    tag_err_d = tag_err_q;
    cmd_x_d   = cmd_hs ? xs_next(cmd_x_q) : cmd_x_q;
    ad_x_d    = ad_hs ? xs_next(ad_x_q) : ad_x_q;
    d_x_d     = d_hs ? xs_next(d_x_q) : d_x_q;
`ifdef ASCON_BIST_THROTTLE_EN
    thr_x_d   = xs_next(thr_x_q);
`endif

    // Tag collection runs independently of the message FSM.
    if (tag_hs) begin
      if (s_tag_tdata == 128'd0) begin
        if (tags_ok_q != 32'hFFFF_FFFF) tags_ok_d = tags_ok_q + 32'd1;
      end else begin
        if (tag_err_q != 32'hFFFF_FFFF) tag_err_d = tag_err_q + 32'd1;
      end
    end

    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d   = S_CMD;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          msg_cnt_d = '0;
          tags_ok_d = '0;
          tag_err_d = '0;
          cmd_x_d   = SEED;
          ad_x_d    = AD_SEED;
          d_x_d     = D_SEED;
`ifdef ASCON_BIST_THROTTLE_EN
          thr_x_d   = T_SEED;
`endif
        end
      end
      S_CMD: begin
        if (cmd_vld_q) begin
          if (cmd_hs) begin
            cmd_vld_d = 1'b0;
            ad_last_d = cmd_x_q[LEN_W-1:0];
            d_last_d  = cmd_x_q[2*LEN_W-1:LEN_W];
            ad_cnt_d  = '0;
            d_cnt_d   = '0;
            ad_done_d = 1'b0;
            d_done_d  = 1'b0;
            state_d   = S_STREAM;
          end
        end else if (g_cmd) begin
          cmd_vld_d = 1'b1;
        end
      end
      S_STREAM: begin
        if (ad_hs) begin
          if (ad_is_last) begin
            ad_vld_d  = 1'b0;
            ad_done_d = 1'b1;
          end else begin
            ad_cnt_d = ad_cnt_q + LEN_W'(1);
          end
        end else if (!ad_vld_q && !ad_done_q && g_ad) begin
          ad_vld_d = 1'b1;
        end
        if (d_hs) begin
          if (d_is_last) begin
            d_vld_d  = 1'b0;
            d_done_d = 1'b1;
          end else begin
            d_cnt_d = d_cnt_q + LEN_W'(1);
          end
        end else if (!d_vld_q && !d_done_q && g_d) begin
          d_vld_d = 1'b1;
        end
        if (ad_done_d && d_done_d) begin
          msg_cnt_d = msg_cnt_q + 32'd1;
          state_d   = (msg_cnt_d < NUM_MSGS) ? S_CMD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (({1'b0, tags_ok_q} + {1'b0, tag_err_q}) == 33'(NUM_MSGS)) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cmd_vld_q <= 1'b0;
      ad_vld_q  <= 1'b0;
      d_vld_q   <= 1'b0;
      ad_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      ad_cnt_q  <= '0;
      d_cnt_q   <= '0;
      ad_last_q <= '0;
      d_last_q  <= '0;
      msg_cnt_q <= '0;
      tags_ok_q <= '0;
      tag_err_q <= '0;
      cmd_x_q   <= SEED;
      ad_x_q    <= AD_SEED;
      d_x_q     <= D_SEED;
`ifdef ASCON_BIST_THROTTLE_EN
      thr_x_q   <= T_SEED;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cmd_vld_q <= cmd_vld_d;
      ad_vld_q  <= ad_vld_d;
      d_vld_q   <= d_vld_d;
      ad_done_q <= ad_done_d;
      d_done_q  <= d_done_d;
      ad_cnt_q  <= ad_cnt_d;
      d_cnt_q   <= d_cnt_d;
      ad_last_q <= ad_last_d;
      d_last_q  <= d_last_d;
      msg_cnt_q <= msg_cnt_d;
      tags_ok_q <= tags_ok_d;
      tag_err_q <= tag_err_d;
      cmd_x_q   <= cmd_x_d;
      ad_x_q    <= ad_x_d;
      d_x_q     <= d_x_d;
`ifdef ASCON_BIST_THROTTLE_EN
      thr_x_q   <= thr_x_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_ascon_bist.sv
// Bench for axis_ascon_bist: a precomputed message plan from a xorshift64 model is compared
// against every accepted beat, with random stalls, an injected bad tag and a mid-run reset.
module tb_axis_ascon_bist;

  localparam int unsigned N     = 5;
  localparam int unsigned LEN_W = 3;
  localparam logic [63:0] SEED  = 64'h0123456789ABCDEF;

  logic         clk, rst, start, busy, done;
  logic [31:0]  tags_ok, tag_errors;
  logic         m_cmd_tvalid, m_cmd_tready;
  logic [511:0] m_cmd_tdata;
  logic         m_ad_tvalid, m_ad_tready, m_ad_tlast;
  logic [127:0] m_ad_tdata;
  logic [15:0]  m_ad_tkeep;
  logic         m_tvalid, m_tready, m_tlast;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         s_tag_tvalid, s_tag_tready;
  logic [127:0] s_tag_tdata;

  axis_ascon_bist #(.NUM_MSGS(N), .LEN_W(LEN_W), .SEED(SEED), .KEEP_SUPPORT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .tags_ok(tags_ok), .tag_errors(tag_errors),
    .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready), .m_cmd_tdata(m_cmd_tdata),
    .m_ad_tvalid(m_ad_tvalid), .m_ad_tready(m_ad_tready), .m_ad_tlast(m_ad_tlast),
    .m_ad_tdata(m_ad_tdata), .m_ad_tkeep(m_ad_tkeep),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .s_tag_tvalid(s_tag_tvalid), .s_tag_tready(s_tag_tready), .s_tag_tdata(s_tag_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic [15:0]  keep;
  } beat_t;

  beat_t        ad_plan[$];
  beat_t        d_plan[$];
  logic [511:0] cmd_plan[$];
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_xs(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    return t ^ (t << 17);
  endfunction

  function automatic logic [63:0] m_rot(input logic [63:0] x);
    return (x << 29) | (x >> 35);
  endfunction

  function automatic logic [15:0] m_keep(input logic [15:0] v);
    int h;
    h = 0;
    for (int b = 0; b < 16; b++) if (v[b]) h = b;
    return 16'((32'd1 << (h + 1)) - 32'd1);
  endfunction

  function automatic beat_t m_beat(input logic [63:0] x, input bit last);
    beat_t b;
    b.data = {x, m_rot(x)};
    b.last = last;
    b.keep = last ? m_keep(x[15:0]) : 16'hFFFF;
    return b;
  endfunction

  task automatic build_plan();
    logic [63:0]  cx, ax, dx;
    logic [511:0] c;
    int           al, dl;
    cmd_plan.delete();
    ad_plan.delete();
    d_plan.delete();
    cx = SEED;
    ax = SEED ^ 64'hA5A5A5A5A5A5A5A5;
    dx = SEED ^ 64'h5A5A5A5A5A5A5A5A;
    for (int m = 0; m < int'(N); m++) begin
      for (int i = 0; i < 4; i++) c[128*i +: 128] = {cx ^ 64'(i), m_rot(cx)};
      c[256] = 1'b1;
      cmd_plan.push_back(c);
      al = int'(cx % 64'd8) + 1;
      dl = int'((cx / 64'd8) % 64'd8) + 1;
      cx = m_xs(cx);
      for (int b = 0; b < al; b++) begin
        ad_plan.push_back(m_beat(ax, b == al - 1));
        ax = m_xs(ax);
      end
      for (int b = 0; b < dl; b++) begin
        d_plan.push_back(m_beat(dx, b == dl - 1));
        dx = m_xs(dx);
      end
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_tvalid"}, m_cmd_tvalid, 1'b0);
    chk({tag, "_ad_tvalid"}, m_ad_tvalid, 1'b0);
    chk({tag, "_tvalid"}, m_tvalid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_tags_ok"}, tags_ok, 32'd0);
    chk({tag, "_tag_errors"}, tag_errors, 32'd0);
    chk({tag, "_tag_tready"}, s_tag_tready, 1'b0);
  endtask

  // One full run; abort_at > 0 resets the DUT once that many AD beats have been taken.
  task automatic run(input bit stall, input int bad_idx, input int abort_at);
    int           ci, ai, di, cycles, ok_e, err_e;
    int           tagq[$];
    bit           tag_v, tag_hs, c_hs, a_hs, x_hs, p_cv, p_av, p_dv;
    logic [127:0] tag_d;
    logic [511:0] p_cd;
    logic [144:0] p_ab, p_db, exp_b;
    ci = 0; ai = 0; di = 0; cycles = 0; ok_e = 0; err_e = 0;
    tag_v = 0; tag_hs = 0; c_hs = 0; a_hs = 0; x_hs = 0; p_cv = 0; p_av = 0; p_dv = 0;
    tag_d = '0; p_cd = '0; p_ab = '0; p_db = '0;
    build_plan();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    while (done !== 1'b1 && cycles < 20000) begin
      if (p_cv && !c_hs) begin
        chk("cmd_hold_valid", m_cmd_tvalid, 1'b1);
        chk("cmd_hold_data", m_cmd_tdata, p_cd);
      end
      if (p_av && !a_hs) begin
        chk("ad_hold_valid", m_ad_tvalid, 1'b1);
        chk("ad_hold_beat", {m_ad_tlast, m_ad_tkeep, m_ad_tdata}, p_ab);
      end
      if (p_dv && !x_hs) begin
        chk("d_hold_valid", m_tvalid, 1'b1);
        chk("d_hold_beat", {m_tlast, m_tkeep, m_tdata}, p_db);
      end
      if (tag_hs) tag_v = 0;
      start        = (stall && cycles == 40) ? 1'b1 : 1'b0;
      m_cmd_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_ad_tready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_tready     = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!tag_v && tagq.size() > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
        tag_v = 1;
        tag_d = (tagq.pop_front() != 0) ? 128'h1 : 128'h0;
      end
      s_tag_tvalid = tag_v;
      s_tag_tdata  = tag_d;
      c_hs   = m_cmd_tvalid && m_cmd_tready;
      a_hs   = m_ad_tvalid && m_ad_tready;
      x_hs   = m_tvalid && m_tready;
      tag_hs = tag_v && s_tag_tready;
      if (c_hs) begin
        chk("cmd_data", m_cmd_tdata, (ci < cmd_plan.size()) ? cmd_plan[ci] : {512{1'bx}});
        tagq.push_back((ci == bad_idx) ? 1 : 0);
        ci++;
      end
      if (a_hs) begin
        exp_b = (ai < ad_plan.size()) ? {ad_plan[ai].last, ad_plan[ai].keep, ad_plan[ai].data} : {145{1'bx}};
        chk("ad_beat", {m_ad_tlast, m_ad_tkeep, m_ad_tdata}, exp_b);
        ai++;
      end
      if (x_hs) begin
        exp_b = (di < d_plan.size()) ? {d_plan[di].last, d_plan[di].keep, d_plan[di].data} : {145{1'bx}};
        chk("d_beat", {m_tlast, m_tkeep, m_tdata}, exp_b);
        di++;
      end
      if (tag_hs) begin
        if (tag_d == 128'h0) ok_e++;
        else err_e++;
      end
      p_cv = m_cmd_tvalid; p_cd = m_cmd_tdata;
      p_av = m_ad_tvalid;  p_ab = {m_ad_tlast, m_ad_tkeep, m_ad_tdata};
      p_dv = m_tvalid;     p_db = {m_tlast, m_tkeep, m_tdata};
      if (abort_at > 0 && ai >= abort_at) begin
        rst = 1'b1;
        s_tag_tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_values("abort");
        return;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    s_tag_tvalid = 1'b0;
    chk("run_done", done, 1'b1);
    chk("run_busy", busy, 1'b0);
    chk("run_tags_ok", tags_ok, 32'(ok_e));
    chk("run_tag_errors", tag_errors, 32'(err_e));
    chk("run_tag_total", 32'(ok_e + err_e), 32'(N));
    chk("run_cmd_count", 32'(ci), 32'(cmd_plan.size()));
    chk("run_ad_count", 32'(ai), 32'(ad_plan.size()));
    chk("run_d_count", 32'(di), 32'(d_plan.size()));
    chk("run_tag_tready_idle", s_tag_tready, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    m_cmd_tready = 1'b0; m_ad_tready = 1'b0; m_tready = 1'b0;
    s_tag_tvalid = 1'b0; s_tag_tdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_values("reset");
    run(1'b0, -1, 0);
    run(1'b1, 2, 0);
    chk("bad_tag_errors", tag_errors, 32'd1);
    run(1'b1, -1, 3);
    run(1'b1, -1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
